step_scheduler: RTL and testbench

Sequencing controller for the 3-bit state counter that feeds the 7-segment display. It turns the raw operator inputs (mode switch, trigger button, speed up/down buttons) into clean one-cycle step pulses. In manual mode each pulse is one trigger press; in auto mode pulses come from a speed-dependent timer, with pause/resume on the trigger button. It also owns the saturating speed register and the mode/pause indicators that the display logic shows.

---
 rtl/step_sched_pkg.sv | 16 +
 rtl/btn_debounce.sv | 49 ++++
 rtl/step_scheduler.sv | 123 ++++++++++++
 tb/tb_step_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/step_sched_pkg.sv
// Shared definitions for the step scheduler: the FSM state type and the
// speed range limits used by the speed register and the auto timer.
package step_sched_pkg;

    localparam int SPEED_MIN = 1;
    localparam int SPEED_MAX = 7;
    localparam int SPEED_W   = 3;

    // Encoding 3 is unused; the FSM default branch returns it to MANUAL.
    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        AUTO_RUN   = 2'd1,
        AUTO_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-level debounce and
// rising-edge detect.
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw asynchronous button level
//   level    : debounced level
//   press    : one-cycle pulse after each accepted rising level
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          s1, s2;
    logic          db, db_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            db      <= 1'b0;
            db_prev <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            db_prev <= db;
            // Any sample that agrees with the accepted level restarts the
            // count, so only an unbroken run of differing samples flips db.
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = db;
    assign press = db & ~db_prev;

endmodule

// File: rtl/step_scheduler.sv
// Step pulse generator for the 7-segment state counter. Manual mode emits
// one step per trigger press; auto mode emits steps from a speed-dependent
// timer with pause/resume on the trigger.
//   clk, rst          : clock, synchronous active-high reset
//   mode              : 0 manual, 1 auto (synchronized, not debounced)
//   trig              : raw trigger button
//   spd_up, spd_down  : raw speed buttons
//   step              : registered one-cycle advance pulse
//   speed             : registered speed, 1..7
//   mode_led          : high in AUTO_RUN or AUTO_PAUSE
//   pause_led         : high in AUTO_PAUSE
module step_scheduler
    import step_sched_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BASE_PERIOD     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               trig,
    input  logic               spd_up,
    input  logic               spd_down,
    output logic               step,
    output logic [SPEED_W-1:0] speed,
    output logic               mode_led,
    output logic               pause_led
);
    localparam int TW = $clog2(7 * BASE_PERIOD);

    logic               mode_s1, mode_s2;
    logic               trig_press, up_press, dn_press;
    state_e             state, state_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic               step_nxt;
    logic [SPEED_W-1:0] speed_nxt;
    logic [TW:0]        lim;
    logic               wrap;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trig (
        .clk(clk), .rst(rst), .btn(trig), .level(), .press(trig_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst(rst), .btn(spd_up), .level(), .press(up_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
        .clk(clk), .rst(rst), .btn(spd_down), .level(), .press(dn_press)
    );

    // Period minus one; >= rather than == so a speed increase that drops
    // the limit below the running count fires on the next cycle.
    assign lim  = (TW+1)'(BASE_PERIOD * (SPEED_MAX + 1 - int'(speed)) - 1);
    assign wrap = ({1'b0, timer} >= lim);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        step_nxt  = 1'b0;
        case (state)
            MANUAL: begin
                timer_nxt = '0;
                if (mode_s2) state_nxt = AUTO_RUN;
                else         step_nxt  = trig_press;
            end
            AUTO_RUN: begin
                if (!mode_s2) begin
                    state_nxt = MANUAL;
                    timer_nxt = '0;
                end else if (trig_press) begin
                    state_nxt = AUTO_PAUSE;
                end else if (wrap) begin
                    step_nxt  = 1'b1;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            AUTO_PAUSE: begin
                if (!mode_s2) begin
                    state_nxt = MANUAL;
                    timer_nxt = '0;
                end else if (trig_press) begin
                    state_nxt = AUTO_RUN;
                end
            end
            default: begin
                state_nxt = MANUAL;
                timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        speed_nxt = speed;
        if (up_press && !dn_press && speed != SPEED_W'(SPEED_MAX))
            speed_nxt = speed + 1'b1;
        else if (dn_press && !up_press && speed != SPEED_W'(SPEED_MIN))
            speed_nxt = speed - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s1   <= 1'b0;
            mode_s2   <= 1'b0;
            state     <= MANUAL;
            timer     <= '0;
            step      <= 1'b0;
            speed     <= SPEED_W'(SPEED_MIN);
            mode_led  <= 1'b0;
            pause_led <= 1'b0;
        end else begin
            mode_s1   <= mode;
            mode_s2   <= mode_s1;
            state     <= state_nxt;
            timer     <= timer_nxt;
            step      <= step_nxt;
            speed     <= speed_nxt;
            mode_led  <= (state_nxt == AUTO_RUN) || (state_nxt == AUTO_PAUSE);
            pause_led <= (state_nxt == AUTO_PAUSE);
        end
    end

endmodule

// File: tb/tb_step_scheduler.sv
module tb_step_scheduler;
    localparam int D  = 4;
    localparam int BP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0, trig = 1'b0, spd_up = 1'b0, spd_down = 1'b0;
    logic       step, mode_led, pause_led;
    logic [2:0] speed;

    step_scheduler #(.DEBOUNCE_CYCLES(D), .BASE_PERIOD(BP)) dut (
        .clk(clk), .rst(rst), .mode(mode), .trig(trig), .spd_up(spd_up),
        .spd_down(spd_down), .step(step), .speed(speed),
        .mode_led(mode_led), .pause_led(pause_led)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model. A button level is accepted once the last D
    // synchronized samples all disagree with the current accepted level;
    // the synchronized sample seen at an edge is the raw value from two
    // edges earlier. hist[b][i] = raw sampled i+1 edges ago.
    int  hist[3][D+1];
    int  mhist[2];
    bit  lvl[3], rose[3];
    int  m_state, m_speed, m_cnt, m_per;
    bit  m_step, tp, upp, dnp, all_diff, started;
    int  cyc = 0;
    int  exp_q[$];

    function automatic int raw_of(int b);
        case (b)
            0:       return int'(trig);
            1:       return int'(spd_up);
            default: return int'(spd_down);
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_step = 0;
        if (rst) begin
            started = 1;
            for (int b = 0; b < 3; b++) begin
                for (int j = 0; j <= D; j++) hist[b][j] = 0;
                lvl[b] = 0; rose[b] = 0;
            end
            mhist[0] = 0; mhist[1] = 0;
            m_state = 0; m_speed = 1; m_cnt = 0;
        end else begin
            tp = rose[0]; upp = rose[1]; dnp = rose[2];
            m_per = BP * (8 - m_speed);
            case (m_state)
                0: begin
                    m_cnt = 0;
                    if (mhist[1] != 0) m_state = 1; else m_step = tp;
                end
                1: begin
                    if (mhist[1] == 0) begin m_state = 0; m_cnt = 0; end
                    else if (tp) m_state = 2;
                    else if (m_cnt + 1 >= m_per) begin m_step = 1; m_cnt = 0; end
                    else m_cnt++;
                end
                default: begin
                    if (mhist[1] == 0) begin m_state = 0; m_cnt = 0; end
                    else if (tp) m_state = 1;
                end
            endcase
            if (upp && !dnp) m_speed = (m_speed < 7) ? m_speed + 1 : 7;
            if (dnp && !upp) m_speed = (m_speed > 1) ? m_speed - 1 : 1;
            for (int b = 0; b < 3; b++) begin
                all_diff = 1;
                for (int j = 1; j <= D; j++)
                    if ((hist[b][j] != 0) == lvl[b]) all_diff = 0;
                rose[b] = all_diff && !lvl[b];
                if (all_diff) lvl[b] = !lvl[b];
                for (int j = D; j >= 1; j--) hist[b][j] = hist[b][j-1];
                hist[b][0] = raw_of(b);
            end
            mhist[1] = mhist[0];
            mhist[0] = int'(mode);
        end
        if (m_step) exp_q.push_back(cyc);
    end

    // Monitor: consumes expected step times, tracks observed step history.
    int step_cnt = 0, last_step = 0, prev_step = 0;
    always @(negedge clk) begin
        if (started) begin
            if (step) begin
                step_cnt++;
                prev_step = last_step;
                last_step = cyc;
                if (exp_q.size() == 0) chk("unexpected_step", cyc, -1);
                else chk("step_time", cyc, exp_q.pop_front());
            end else if (exp_q.size() != 0 && exp_q[0] <= cyc) begin
                chk("missed_step", -1, exp_q.pop_front());
            end
            chk("speed", int'(speed), m_speed);
            chk("mode_led", int'(mode_led), int'(m_state != 0));
            chk("pause_led", int'(pause_led), int'(m_state == 2));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       trig = v;
            1:       spd_up = v;
            default: spd_down = v;
        endcase
    endtask

    task automatic press(input int b, input int hold, input int gap);
        set_btn(b, 1'b1); tick(hold);
        set_btn(b, 1'b0); tick(gap);
    endtask

    task automatic wait_steps(input string name, input int n, input int limit);
        int target, k;
        target = step_cnt + n;
        k = 0;
        while (step_cnt < target && k < limit) begin tick(1); k++; end
        if (step_cnt < target) chk(name, step_cnt, target);
    endtask

    int c0, sc;

    initial begin
        // 1. reset
        tick(2);
        rst = 1'b0;
        chk("rst_step", int'(step), 0);
        chk("rst_speed", int'(speed), 1);
        chk("rst_mode_led", int'(mode_led), 0);
        chk("rst_pause_led", int'(pause_led), 0);
        tick(100);
        chk("idle_steps", step_cnt, 0);

        // 2. manual trigger
        c0 = cyc; sc = step_cnt;
        press(0, 10, 12);
        chk("manual_one_step", step_cnt - sc, 1);
        chk("manual_latency", last_step - c0, 7);
        sc = step_cnt;
        press(0, 3, 12);
        chk("glitch_no_step", step_cnt - sc, 0);

        // 3. speed saturation
        for (int i = 0; i < 8; i++) begin
            press(1, 6, 8);
            chk("speed_up", int'(speed), (i + 2 > 7) ? 7 : i + 2);
        end
        for (int i = 0; i < 8; i++) begin
            press(2, 6, 8);
            chk("speed_down", int'(speed), (6 - i < 1) ? 1 : 6 - i);
        end
        press(1, 6, 8); press(1, 6, 8);
        spd_up = 1'b1; spd_down = 1'b1; tick(6);
        spd_up = 1'b0; spd_down = 1'b0; tick(8);
        chk("speed_both", int'(speed), 3);

        // 4. auto rate
        repeat (4) press(1, 6, 8);
        chk("speed_max", int'(speed), 7);
        mode = 1'b1;
        wait_steps("auto7_timeout", 3, 100);
        chk("spacing_7", last_step - prev_step, 8);
        repeat (6) press(2, 5, 6);
        chk("speed_min", int'(speed), 1);
        wait_steps("auto1_timeout", 2, 200);
        chk("spacing_1", last_step - prev_step, 56);
        tick(20);
        repeat (6) press(1, 5, 6);
        wait_steps("auto_fast_timeout", 2, 100);
        chk("spacing_fast", last_step - prev_step, 8);

        // 5. pause / resume
        press(0, 6, 10);
        chk("paused_led", int'(pause_led), 1);
        sc = step_cnt;
        tick(200);
        chk("paused_no_steps", step_cnt - sc, 0);
        press(0, 6, 2);
        chk("resumed_led", int'(pause_led), 0);
        wait_steps("resume_timeout", 2, 40);

        // 6. mode exit, reset mid-run
        mode = 1'b0;
        tick(3);
        chk("exit_mode_led", int'(mode_led), 0);
        sc = step_cnt;
        tick(100);
        chk("manual_no_steps", step_cnt - sc, 0);
        mode = 1'b1;
        press(2, 6, 8); press(2, 6, 8);
        chk("speed_5", int'(speed), 5);
        tick(30);
        rst = 1'b1; tick(1);
        chk("midrst_speed", int'(speed), 1);
        chk("midrst_mode_led", int'(mode_led), 0);
        chk("midrst_pause_led", int'(pause_led), 0);
        chk("midrst_step", int'(step), 0);
        rst = 1'b0;

        // randomized traffic, checked entirely by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) trig = ~trig;
            if ($urandom_range(0, 9) == 0) spd_up = ~spd_up;
            if ($urandom_range(0, 9) == 0) spd_down = ~spd_down;
            if ($urandom_range(0, 299) == 0) mode = ~mode;
            tick(1);
        end
        trig = 1'b0; spd_up = 1'b0; spd_down = 1'b0; mode = 1'b0;
        tick(20);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
